vote_recorder: RTL and testbench

VOTE_RECORDER -- requirements
Module: vote_recorder

---
 rtl/vote_recorder.sv | 168 ++++++++++++++++
 tb/tb_vote_recorder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vote_recorder.sv
// Four-button vote recorder: per-button 2-flop synchronizers feed a debounce/commit/lockout
// FSM that adds one saturating vote per held press.

module vote_recorder_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module vote_recorder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       candidate1_button,
  input  logic       candidate2_button,
  input  logic       candidate3_button,
  input  logic       candidate4_button,
  output logic [7:0] candidate1_vote,
  output logic [7:0] candidate2_vote,
  output logic [7:0] candidate3_vote,
  output logic [7:0] candidate4_vote,
  output logic [9:0] total_votes,
  output logic       valid_vote_casted,
  output logic       busy
);
  localparam int NUM_CAND = 4;
  localparam logic [3:0] DEB = 4'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, COMMIT, LOCKOUT} state_t;

  logic [NUM_CAND-1:0]      btn_raw, btn_s;
  logic [NUM_CAND-1:0][7:0] tally;
  logic [9:0]               total;
  state_t                   state, state_nxt;
  logic [3:0]               cnt, cnt_nxt;
  logic [1:0]               idx, idx_nxt, first_idx;
  logic                     any_high, multi_high, cap_high, other_high;
  logic [2:0]               n_high;

  assign btn_raw = {candidate4_button, candidate3_button, candidate2_button, candidate1_button};

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_sync
    vote_recorder_sync u_sync (
      .clock (clock),
      .reset (reset),
      .d     (btn_raw[g]),
      .q     (btn_s[g])
    );
  end

  always_comb begin
    n_high    = '0;
    first_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      n_high = n_high + 3'(btn_s[i]);
      if (btn_s[i]) first_idx = 2'(i);
    end
  end

  assign any_high   = |btn_s;
  assign multi_high = (n_high > 3'd1);
  assign cap_high   = btn_s[idx];
  assign other_high = |(btn_s & ~(4'b0001 << idx));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        if (mode) begin
          if (any_high) begin
            state_nxt = LOCKOUT;
            cnt_nxt   = '0;
          end
        end else if (multi_high) begin
          state_nxt = LOCKOUT;
          cnt_nxt   = '0;
        end else if (any_high) begin
          state_nxt = DEBOUNCE;
          idx_nxt   = first_idx;
          cnt_nxt   = 4'd1;
        end
      end
      DEBOUNCE: begin
        if (mode || other_high) begin
          state_nxt = any_high ? LOCKOUT : IDLE;
          cnt_nxt   = '0;
        end else if (cap_high) begin
          if (cnt == DEB) state_nxt = COMMIT;
          else            cnt_nxt   = cnt + 4'd1;
        end else begin
          // glitch: released before it was stable long enough
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      COMMIT: begin
        state_nxt = LOCKOUT;
        cnt_nxt   = '0;
      end
      LOCKOUT: begin
        // wait for DEBOUNCE_CYCLES consecutive all-released cycles
        if (any_high) begin
          cnt_nxt = '0;
        end else if (cnt + 4'd1 == DEB) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // tallies move only on the edge that closes COMMIT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tally             <= '0;
      total             <= '0;
      valid_vote_casted <= 1'b0;
    end else begin
      valid_vote_casted <= (state_nxt == COMMIT);
      if (state == COMMIT) begin
        if (tally[idx] != 8'hFF)  tally[idx] <= tally[idx] + 8'd1;
        if (total != 10'h3FF)     total      <= total + 10'd1;
      end
    end
  end

  assign candidate1_vote = tally[0];
  assign candidate2_vote = tally[1];
  assign candidate3_vote = tally[2];
  assign candidate4_vote = tally[3];
  assign total_votes     = total;
  assign busy            = (state != IDLE);
endmodule

// File: tb/tb_vote_recorder.sv
// Scoreboard bench for vote_recorder: the stimulus thread predicts each vote from the
// press pattern, a monitor pops a prediction per valid_vote_casted pulse and checks tallies.

module tb_vote_recorder;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode  = 1'b0;
  logic [3:0] btn   = '0;
  logic [7:0] c1v, c2v, c3v, c4v;
  logic [9:0] tot;
  logic       valid, busy;

  typedef struct packed {
    logic [3:0][7:0] c;
    logic [9:0]      t;
  } exp_t;

  exp_t exp_q[$];
  int   m_tally[4];
  int   m_total;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pulses = 0;

  vote_recorder #(.DEBOUNCE_CYCLES(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .mode              (mode),
    .candidate1_button (btn[0]),
    .candidate2_button (btn[1]),
    .candidate3_button (btn[2]),
    .candidate4_button (btn[3]),
    .candidate1_vote   (c1v),
    .candidate2_vote   (c2v),
    .candidate3_vote   (c3v),
    .candidate4_vote   (c4v),
    .total_votes       (tot),
    .valid_vote_casted (valid),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    check({name, " c1"}, c1v, m_tally[0]);
    check({name, " c2"}, c2v, m_tally[1]);
    check({name, " c3"}, c3v, m_tally[2]);
    check({name, " c4"}, c4v, m_tally[3]);
    check({name, " total"}, tot, m_total);
  endtask

  // reference: one accepted vote, saturating counters
  task automatic predict_vote(input int k);
    exp_t e;
    if (m_tally[k] < 255) m_tally[k]++;
    if (m_total < 1023)   m_total++;
    for (int i = 0; i < 4; i++) e.c[i] = 8'(m_tally[i]);
    e.t = 10'(m_total);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 4; i++) m_tally[i] = 0;
    m_total = 0;
    exp_q.delete();
    reset = 1'b0;
  endtask

  // raw press of pattern m held for hold cycles, then gap idle cycles
  task automatic press(input logic [3:0] m, input int hold, input int gap);
    @(negedge clock);
    if (!mode && $countones(m) == 1 && hold >= 6) begin
      for (int i = 0; i < 4; i++) if (m[i]) predict_vote(i);
    end
    btn = m;
    repeat (hold) @(negedge clock);
    btn = '0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic drain(input string name);
    int waited = 0;
    while ((exp_q.size() != 0 || busy) && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check({name, " drain timeout"}, int'(waited < 200), 1);
    check({name, " idle"}, busy, 0);
  endtask

  // monitor: each pulse pops a prediction; tallies checked the cycle after the pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && valid) begin
        n_pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          @(negedge clock);
          check("pulse width", valid, 0);
          check("mon c1", c1v, e.c[0]);
          check("mon c2", c2v, e.c[1]);
          check("mon c3", c3v, e.c[2]);
          check("mon c4", c4v, e.c[3]);
          check("mon total", tot, e.t);
        end
      end
    end
  end

  initial begin
    logic [3:0] m;
    int a, b, r;

    #1;
    check("reset valid", valid, 0);
    check("reset busy", busy, 0);
    check("reset total", tot, 0);
    do_reset();
    repeat (3) @(negedge clock);

    // single held press: pulse after edge 7, tally moves at edge 8
    @(negedge clock);
    predict_vote(1);
    btn = 4'b0010;
    repeat (6) @(posedge clock);
    #1 check("latency edge6 valid", valid, 0);
    @(posedge clock);
    #1 check("latency edge7 valid", valid, 1);
    check("latency edge7 c2", c2v, 0);
    @(posedge clock);
    #1 check("latency edge8 c2", c2v, 1);
    check("latency edge8 valid", valid, 0);
    repeat (12) @(negedge clock);
    btn = '0;
    drain("held press");
    check_model("held press");

    // short glitch rejected
    press(4'b0100, 2, 2);
    repeat (6) @(negedge clock);
    check("glitch busy", busy, 0);
    check_model("glitch");

    // two buttons together lock out
    press(4'b1001, 15, 0);
    repeat (7) @(negedge clock);
    check("multi busy", busy, 0);
    check_model("multi");

    // mode switch mid-debounce discards the press; tallies persist
    @(negedge clock);
    btn = 4'b0010;
    repeat (4) @(negedge clock);
    mode = 1'b1;
    repeat (10) @(negedge clock);
    mode = 1'b0;
    repeat (6) @(negedge clock);
    btn = '0;
    repeat (12) @(negedge clock);
    check("mode abort busy", busy, 0);
    check_model("mode abort");
    mode = 1'b1;
    press(4'b0001, 12, 12);
    mode = 1'b0;
    check_model("result mode");

    // randomized mix of votes, glitches and multi-presses
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 3);
      if (r <= 5) begin
        m = 4'b0001 << a;
        press(m, $urandom_range(6, 20), $urandom_range(10, 16));
      end else if (r <= 7) begin
        m = 4'b0001 << a;
        press(m, $urandom_range(1, 2), $urandom_range(10, 16));
      end else begin
        b = (a + $urandom_range(1, 3)) % 4;
        m = (4'b0001 << a) | (4'b0001 << b);
        press(m, $urandom_range(3, 15), $urandom_range(10, 16));
      end
    end
    drain("random");
    check_model("random");

    // saturation: 260 presses of candidate 1
    do_reset();
    repeat (3) @(negedge clock);
    n_pulses = 0;
    for (int n = 0; n < 260; n++) press(4'b0001, 6, 9);
    drain("saturate");
    check("saturate c1", c1v, 255);
    check("saturate total", tot, 260);
    check("saturate pulses", n_pulses, 260);
    check_model("saturate");

    // reset during COMMIT discards the vote
    @(negedge clock);
    btn = 4'b0100;
    repeat (7) @(posedge clock);
    #1 check("commit valid", valid, 1);
    reset = 1'b1;
    #1 check("reset mid-commit valid", valid, 0);
    check("reset mid-commit busy", busy, 0);
    check("reset mid-commit c1", c1v, 0);
    check("reset mid-commit total", tot, 0);
    btn = '0;
    do_reset();
    repeat (10) @(negedge clock);
    check_model("after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
